// File: rtl/mesh_noc_pkg.sv
// Shared NoC definitions: flit field positions, port indices, ejector register map.
package mesh_noc_pkg;

  localparam int unsigned FLIT_W    = 34;
  localparam int unsigned PAY_W     = 29;
  localparam int unsigned ID_W      = 4;
  localparam int unsigned NPORTS    = 8;
  localparam int unsigned PORT_W    = 3;
  localparam int unsigned VALID_BIT = 33;
  localparam int unsigned DEST_HI   = 32;
  localparam int unsigned DEST_LO   = 29;

  localparam logic [PORT_W-1:0] PORT_N  = 3'd0;
  localparam logic [PORT_W-1:0] PORT_S  = 3'd1;
  localparam logic [PORT_W-1:0] PORT_E  = 3'd2;
  localparam logic [PORT_W-1:0] PORT_W_ = 3'd3;
  localparam logic [PORT_W-1:0] PORT_NE = 3'd4;
  localparam logic [PORT_W-1:0] PORT_NW = 3'd5;
  localparam logic [PORT_W-1:0] PORT_SE = 3'd6;
  localparam logic [PORT_W-1:0] PORT_SW = 3'd7;

  localparam logic [1:0] REG_DATA   = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_DROPS  = 2'd2;
  localparam logic [1:0] REG_CTRL   = 2'd3;

  localparam logic [3:0] EJ_BASE = 4'h9;

  // Receive FIFO word: source port above the flit payload.
  typedef struct packed {
    logic [PORT_W-1:0] port;
    logic [PAY_W-1:0]  payload;
  } ej_word_t;

  function automatic logic flit_hit(input logic [FLIT_W-1:0] f, input logic [ID_W-1:0] id);
    return f[VALID_BIT] && (f[DEST_HI:DEST_LO] == id);
  endfunction

endpackage

// File: rtl/ej_fifo.sv
// Synchronous FIFO with extra-bit wrap pointers and a single-cycle flush.
module ej_fifo #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned W     = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic                     flush_i,
  input  logic [W-1:0]             din_i,
  output logic [W-1:0]             dout_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [CW-1:0] wr_q, wr_d;
  logic [CW-1:0] rd_q, rd_d;

  always_comb begin
    wr_d = wr_q + CW'(push_i);
    rd_d = rd_q + CW'(pop_i);
    if (flush_i) begin
      wr_d = '0;
      rd_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

  // Storage needs no reset; pointers define validity.
  always_ff @(posedge clk) begin
    if (push_i && !flush_i) mem_q[wr_q[AW-1:0]] <= din_i;
  end

  assign count_o = wr_q - rd_q;
  assign full_o  = (count_o == CW'(DEPTH));
  assign empty_o = (count_o == '0);
  assign dout_o  = mem_q[rd_q[AW-1:0]];

endmodule

// File: rtl/mesh_ejector.sv
// Mesh node eject path: captures flits addressed to MY_ID from 8 links, buffers
// them per port, arbitrates into a receive FIFO and exposes it over Wishbone.
module mesh_ejector
  import mesh_noc_pkg::*;
#(
  parameter logic [3:0]  MY_ID = 4'b0000,
  parameter int unsigned DEPTH = 8,
  parameter logic [3:0]  BASE  = EJ_BASE
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       local_wb_adr,
  input  logic [31:0]       local_wb_dat_o,
  output logic [31:0]       local_wb_dat_i,
  input  logic              local_wb_we,
  input  logic              local_wb_stb,
  output logic              local_wb_ack,
  input  logic [FLIT_W-1:0] n_in,
  input  logic [FLIT_W-1:0] s_in,
  input  logic [FLIT_W-1:0] e_in,
  input  logic [FLIT_W-1:0] w_in,
  input  logic [FLIT_W-1:0] ne_in,
  input  logic [FLIT_W-1:0] nw_in,
  input  logic [FLIT_W-1:0] se_in,
  input  logic [FLIT_W-1:0] sw_in,
  output logic              rx_irq
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic [FLIT_W-1:0] link_c [NPORTS];
  logic [NPORTS-1:0] hit_c, drop_c;
  logic [NPORTS-1:0] slot_vld_q, slot_vld_d;
  logic [PAY_W-1:0]  slot_pay_q [NPORTS];
  logic [PAY_W-1:0]  slot_pay_d [NPORTS];
  logic [PORT_W-1:0] rr_q, rr_d, gnt_idx_c;
  logic              gnt_any_c;
  logic [7:0]        overflow_q, overflow_d;
  logic [15:0]       drop_cnt_q, drop_cnt_d;
  logic              ack_q, ack_d;
  logic [31:0]       dat_q, dat_d, rdata_c;
  logic              irq_q, irq_d;
  logic              sel_c, acc_c, rd_c, wr_c, pop_c, flush_c;
  logic [1:0]        reg_c;
  ej_word_t          fifo_din_c, fifo_dout;
  logic              fifo_full, fifo_empty;
  logic [CW-1:0]     fifo_count, cnt_nxt_c;
  logic              unused_c;

  always_comb begin
    link_c[PORT_N]  = n_in;
    link_c[PORT_S]  = s_in;
    link_c[PORT_E]  = e_in;
    link_c[PORT_W_] = w_in;
    link_c[PORT_NE] = ne_in;
    link_c[PORT_NW] = nw_in;
    link_c[PORT_SE] = se_in;
    link_c[PORT_SW] = sw_in;
    for (int p = 0; p < NPORTS; p++) hit_c[p] = flit_hit(link_c[p], MY_ID);
  end

  // Wishbone decode; side effects only on the access edge where ack rises.
  always_comb begin
    sel_c   = local_wb_stb && (local_wb_adr[31:28] == BASE);
    acc_c   = sel_c && !ack_q;
    rd_c    = acc_c && !local_wb_we;
    wr_c    = acc_c && local_wb_we;
    reg_c   = local_wb_adr[3:2];
    pop_c   = rd_c && (reg_c == REG_DATA) && !fifo_empty;
    flush_c = wr_c && (reg_c == REG_CTRL) && local_wb_dat_o[0];
    rdata_c = '0;
    case (reg_c)
      REG_DATA:   rdata_c = fifo_empty ? '0 : fifo_dout;
      REG_STATUS: rdata_c = {16'(fifo_count), overflow_q, 6'b0, fifo_full, fifo_empty};
      REG_DROPS:  rdata_c = {16'b0, drop_cnt_q};
      default:    rdata_c = '0;
    endcase
    ack_d = sel_c && !ack_q;
    dat_d = rd_c ? rdata_c : '0;
  end

  // Round-robin grant from rr_q; a full FIFO accepts only alongside a pop.
  always_comb begin
    gnt_any_c = 1'b0;
    gnt_idx_c = rr_q;
    for (int i = 0; i < NPORTS; i++) begin
      if (!gnt_any_c && slot_vld_q[rr_q + PORT_W'(i)]) begin
        gnt_any_c = 1'b1;
        gnt_idx_c = rr_q + PORT_W'(i);
      end
    end
    if (flush_c || (fifo_full && !pop_c)) gnt_any_c = 1'b0;
    rr_d = gnt_any_c ? gnt_idx_c + 3'd1 : rr_q;
  end

  assign fifo_din_c = '{port: gnt_idx_c, payload: slot_pay_q[gnt_idx_c]};

  // Slot update: free on grant/flush first, so a same-edge hit reloads instead of dropping.
  always_comb begin
    logic [3:0]  ndrop;
    logic [16:0] sum;
    ndrop = '0;
    for (int p = 0; p < NPORTS; p++) begin
      slot_vld_d[p] = slot_vld_q[p];
      slot_pay_d[p] = slot_pay_q[p];
      drop_c[p]     = 1'b0;
      if (flush_c || (gnt_any_c && (gnt_idx_c == PORT_W'(p)))) slot_vld_d[p] = 1'b0;
      if (hit_c[p]) begin
        if (!slot_vld_d[p]) begin
          slot_vld_d[p] = 1'b1;
          slot_pay_d[p] = link_c[p][PAY_W-1:0];
        end else begin
          drop_c[p] = 1'b1;
        end
      end
      ndrop = ndrop + 4'(drop_c[p]);
    end
    overflow_d = overflow_q;
    if (wr_c && (reg_c == REG_STATUS)) overflow_d = overflow_d & ~local_wb_dat_o[15:8];
    overflow_d = overflow_d | drop_c;
    sum = (wr_c && (reg_c == REG_DROPS)) ? 17'(ndrop) : 17'(drop_cnt_q) + 17'(ndrop);
    drop_cnt_d = sum[16] ? 16'hFFFF : sum[15:0];
    cnt_nxt_c  = flush_c ? '0 : fifo_count + CW'(gnt_any_c) - CW'(pop_c);
    irq_d      = (cnt_nxt_c != '0);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      slot_vld_q <= '0;
      for (int p = 0; p < NPORTS; p++) slot_pay_q[p] <= '0;
      rr_q       <= '0;
      overflow_q <= '0;
      drop_cnt_q <= '0;
      ack_q      <= 1'b0;
      dat_q      <= '0;
      irq_q      <= 1'b0;
    end else begin
      slot_vld_q <= slot_vld_d;
      for (int p = 0; p < NPORTS; p++) slot_pay_q[p] <= slot_pay_d[p];
      rr_q       <= rr_d;
      overflow_q <= overflow_d;
      drop_cnt_q <= drop_cnt_d;
      ack_q      <= ack_d;
      dat_q      <= dat_d;
      irq_q      <= irq_d;
    end
  end

  ej_fifo #(
    .DEPTH(DEPTH),
    .W    ($bits(ej_word_t))
  ) u_fifo (
    .clk    (clk),
    .rst_n  (rst),
    .push_i (gnt_any_c),
    .pop_i  (pop_c),
    .flush_i(flush_c),
    .din_i  (fifo_din_c),
    .dout_o (fifo_dout),
    .full_o (fifo_full),
    .empty_o(fifo_empty),
    .count_o(fifo_count)
  );

  assign local_wb_ack   = ack_q;
  assign local_wb_dat_i = dat_q;
  assign rx_irq         = irq_q;
  assign unused_c = ^{local_wb_adr[27:4], local_wb_adr[1:0],
                      local_wb_dat_o[31:16], local_wb_dat_o[7:1]};

endmodule

// File: tb/tb_mesh_ejector.sv
// Randomized self-checking bench for mesh_ejector against a queue-based reference model.
module tb_mesh_ejector;

  localparam logic [3:0] MYID  = 4'h6;
  localparam logic [3:0] BASE  = 4'h9;
  localparam int         DEPTH = 8;

  logic        clk, rst;
  logic [31:0] adr, wdat, rdat;
  logic        we, stb, ack, irq;
  logic [33:0] lnk [8];

  int n_pass, n_checks;

  // Reference model state
  bit          m_slot_v [8];
  logic [28:0] m_slot_p [8];
  logic [31:0] m_fifo [$];
  int          m_rr, m_drops;
  logic [7:0]  m_ovf;
  bit          m_ack, m_irq;
  logic [31:0] m_dat;

  mesh_ejector #(.MY_ID(MYID), .DEPTH(DEPTH), .BASE(BASE)) dut (
    .clk(clk), .rst(rst),
    .local_wb_adr(adr), .local_wb_dat_o(wdat), .local_wb_dat_i(rdat),
    .local_wb_we(we), .local_wb_stb(stb), .local_wb_ack(ack),
    .n_in(lnk[0]), .s_in(lnk[1]), .e_in(lnk[2]), .w_in(lnk[3]),
    .ne_in(lnk[4]), .nw_in(lnk[5]), .se_in(lnk[6]), .sw_in(lnk[7]),
    .rx_irq(irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic m_reset();
    for (int p = 0; p < 8; p++) begin m_slot_v[p] = 0; m_slot_p[p] = '0; end
    m_fifo.delete();
    m_rr = 0; m_drops = 0; m_ovf = '0; m_ack = 0; m_irq = 0; m_dat = '0;
  endtask

  // One clock edge of behaviour, evaluated from the inputs currently driven.
  task automatic model_step();
    bit sel, acc, pop, flush, dclr;
    logic [7:0] clr, dmask;
    logic [31:0] rdata;
    int g, ndrop, sz;
    sel = stb && (adr[31:28] == BASE);
    acc = sel && !m_ack;
    pop = 0; flush = 0; dclr = 0; clr = '0; rdata = '0;
    sz = m_fifo.size();
    if (acc) begin
      case (adr[3:2])
        2'd0: if (!we && sz > 0) begin rdata = m_fifo[0]; pop = 1; end
        2'd1: if (we) clr = wdat[15:8];
              else rdata = {16'(sz), m_ovf, 6'b0, (sz == DEPTH), (sz == 0)};
        2'd2: if (we) dclr = 1; else rdata = {16'b0, 16'(m_drops)};
        default: if (we && wdat[0]) flush = 1;
      endcase
    end
    g = -1;
    if (!flush && (sz < DEPTH || pop))
      for (int k = 0; k < 8; k++) begin
        int p;
        p = (m_rr + k) % 8;
        if (g < 0 && m_slot_v[p]) g = p;
      end
    if (flush) m_fifo.delete();
    else begin
      if (pop) void'(m_fifo.pop_front());
      if (g >= 0) m_fifo.push_back({3'(g), m_slot_p[g]});
    end
    dmask = '0; ndrop = 0;
    for (int p = 0; p < 8; p++) begin
      if (flush || p == g) m_slot_v[p] = 0;
      if (lnk[p][33] && lnk[p][32:29] == MYID) begin
        if (!m_slot_v[p]) begin m_slot_v[p] = 1; m_slot_p[p] = lnk[p][28:0]; end
        else begin dmask[p] = 1'b1; ndrop++; end
      end
    end
    m_ovf = (m_ovf & ~clr) | dmask;
    if (dclr) m_drops = 0;
    m_drops += ndrop;
    if (m_drops > 65535) m_drops = 65535;
    if (g >= 0) m_rr = (g + 1) % 8;
    m_ack = sel && !m_ack;
    m_dat = (acc && !we) ? rdata : '0;
    m_irq = (m_fifo.size() != 0);
  endtask

  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    stb = 0; we = 0; adr = '0; wdat = '0;
    for (int p = 0; p < 8; p++) lnk[p] = '0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 0;
    @(posedge clk);
    #1;
    rst = 1;
    m_reset();
  endtask

  // Single Wishbone access; returns what the DUT and the model show on the ack cycle.
  task automatic wb_access(input bit w, input logic [1:0] r, input logic [31:0] d,
                           output logic a, output logic [31:0] got, output logic [31:0] exp);
    stb = 1; we = w; adr = {BASE, 24'h0, r, 2'b00}; wdat = d;
    cycle();
    a = ack; got = rdat; exp = m_dat;
    stb = 0; we = 0; wdat = '0;
    cycle();
  endtask

  task automatic test_reset();
    logic a; logic [31:0] d, e;
    clear_inputs();
    rst = 0;
    repeat (2) @(posedge clk);
    #1;
    n_checks++; if (ack !== 1'b0) $display("FAIL reset_ack: got %b expected 0", ack); else n_pass++;
    n_checks++; if (rdat !== 32'h0) $display("FAIL reset_dat: got %h expected 0", rdat); else n_pass++;
    n_checks++; if (irq !== 1'b0) $display("FAIL reset_irq: got %b expected 0", irq); else n_pass++;
    rst = 1;
    m_reset();
    wb_access(0, 2'd1, '0, a, d, e);
    n_checks++; if (a !== 1'b1) $display("FAIL reset_status_ack: got %b expected 1", a); else n_pass++;
    n_checks++; if (d !== 32'h0000_0001) $display("FAIL reset_status: got %h expected 00000001", d); else n_pass++;
    wb_access(0, 2'd2, '0, a, d, e);
    n_checks++; if (d !== 32'h0) $display("FAIL reset_drops: got %h expected 0", d); else n_pass++;
  endtask

  task automatic test_single_hit();
    logic a; logic [31:0] d, e;
    lnk[2] = {1'b1, MYID, 29'h5};
    cycle();
    lnk[2] = '0;
    n_checks++; if (irq !== 1'b0) $display("FAIL hit_irq_early: got %b expected 0", irq); else n_pass++;
    cycle();
    n_checks++; if (irq !== 1'b1) $display("FAIL hit_irq: got %b expected 1", irq); else n_pass++;
    wb_access(0, 2'd0, '0, a, d, e);
    n_checks++; if (d !== {3'd2, 29'h5} || d !== e) $display("FAIL hit_data: got %h expected %h", d, e); else n_pass++;
    wb_access(0, 2'd1, '0, a, d, e);
    n_checks++; if (d !== 32'h0000_0001) $display("FAIL hit_empty_after: got %h expected 00000001", d); else n_pass++;
    n_checks++; if (irq !== 1'b0) $display("FAIL hit_irq_after: got %b expected 0", irq); else n_pass++;
  endtask

  task automatic test_wrong_dest();
    logic a; logic [31:0] d, e;
    for (int i = 0; i < 4; i++) begin
      lnk[3] = {1'b1, MYID ^ 4'h5, 29'(32'h1234 + i)};
      lnk[5] = {1'b0, MYID, 29'h77};
      cycle();
      n_checks++; if (irq !== 1'b0) $display("FAIL wrong_dest_irq: got %b expected 0", irq); else n_pass++;
    end
    clear_inputs();
    cycle();
    wb_access(0, 2'd1, '0, a, d, e);
    n_checks++; if (d !== 32'h0000_0001) $display("FAIL wrong_dest_status: got %h expected 00000001", d); else n_pass++;
    wb_access(0, 2'd2, '0, a, d, e);
    n_checks++; if (d !== 32'h0) $display("FAIL wrong_dest_drops: got %h expected 0", d); else n_pass++;
  endtask

  task automatic test_all_ports();
    logic a; logic [31:0] d, e;
    do_reset();
    for (int p = 0; p < 8; p++) lnk[p] = {1'b1, MYID, 29'(32'h100 + p)};
    cycle();
    clear_inputs();
    repeat (10) cycle();
    wb_access(0, 2'd1, '0, a, d, e);
    n_checks++; if (d !== 32'h0008_0002) $display("FAIL all_ports_status: got %h expected 00080002", d); else n_pass++;
    for (int i = 0; i < 8; i++) begin
      wb_access(0, 2'd0, '0, a, d, e);
      n_checks++;
      if (d !== {3'(i), 29'(32'h100 + i)} || d !== e) $display("FAIL all_ports_order[%0d]: got %h expected %h", i, d, e);
      else n_pass++;
    end
    wb_access(0, 2'd2, '0, a, d, e);
    n_checks++; if (d !== 32'h0) $display("FAIL all_ports_drops: got %h expected 0", d); else n_pass++;
  endtask

  task automatic test_overflow();
    logic a; logic [31:0] d, e;
    do_reset();
    for (int i = 0; i < DEPTH; i++) begin
      lnk[1] = {1'b1, MYID, 29'(100 + i)};
      cycle();
    end
    clear_inputs();
    repeat (2) cycle();
    wb_access(0, 2'd1, '0, a, d, e);
    n_checks++; if (d !== 32'h0008_0002) $display("FAIL ovf_full_status: got %h expected 00080002", d); else n_pass++;
    lnk[0] = {1'b1, MYID, 29'h1AB};
    repeat (3) cycle();
    clear_inputs();
    cycle();
    wb_access(0, 2'd1, '0, a, d, e);
    n_checks++; if (d !== 32'h0008_0102) $display("FAIL ovf_flag: got %h expected 00080102", d); else n_pass++;
    wb_access(0, 2'd2, '0, a, d, e);
    n_checks++; if (d !== 32'h0000_0002) $display("FAIL ovf_drops: got %h expected 00000002", d); else n_pass++;
    wb_access(1, 2'd1, 32'h0000_0100, a, d, e);
    wb_access(0, 2'd1, '0, a, d, e);
    n_checks++; if (d !== 32'h0008_0002) $display("FAIL ovf_w1c: got %h expected 00080002", d); else n_pass++;
    // Pending slot 0 is pushed on the same edge as this pop.
    wb_access(0, 2'd0, '0, a, d, e);
    n_checks++; if (d !== {3'd1, 29'd100}) $display("FAIL full_pop_data: got %h expected %h", d, {3'd1, 29'd100}); else n_pass++;
    wb_access(0, 2'd1, '0, a, d, e);
    n_checks++; if (d !== 32'h0008_0002) $display("FAIL full_pop_push_count: got %h expected 00080002", d); else n_pass++;
    wb_access(1, 2'd2, '0, a, d, e);
    wb_access(0, 2'd2, '0, a, d, e);
    n_checks++; if (d !== 32'h0) $display("FAIL drops_clear: got %h expected 0", d); else n_pass++;
  endtask

  task automatic test_empty_read();
    logic a; logic [31:0] d, e;
    wb_access(1, 2'd3, 32'h1, a, d, e);
    n_checks++; if (irq !== 1'b0) $display("FAIL flush_irq: got %b expected 0", irq); else n_pass++;
    wb_access(0, 2'd0, '0, a, d, e);
    n_checks++; if (a !== 1'b1 || d !== 32'h0) $display("FAIL empty_read: ack %b data %h expected ack 1 data 0", a, d); else n_pass++;
    wb_access(0, 2'd1, '0, a, d, e);
    n_checks++; if (d !== 32'h0000_0001) $display("FAIL empty_read_status: got %h expected 00000001", d); else n_pass++;
  endtask

  task automatic randomize_inputs();
    logic [3:0] nib;
    for (int p = 0; p < 8; p++) begin
      lnk[p] = '0;
      if ($urandom_range(99) < 25)
        lnk[p] = {1'b1, ($urandom_range(99) < 70) ? MYID : 4'($urandom), 29'($urandom)};
    end
    stb = ($urandom_range(99) < 40);
    we  = $urandom_range(1);
    nib = ($urandom_range(99) < 80) ? BASE : (($urandom_range(1) == 1) ? 4'h8 : 4'($urandom));
    adr = {nib, 24'($urandom), 2'($urandom), 2'($urandom)};
    wdat = $urandom;
    wdat[0] = ($urandom_range(7) == 0);
  endtask

  task automatic test_random();
    for (int i = 0; i < 2000; i++) begin
      randomize_inputs();
      cycle();
      n_checks++; if (ack !== m_ack) $display("FAIL rand_ack[%0d]: got %b expected %b", i, ack, m_ack); else n_pass++;
      n_checks++; if (rdat !== m_dat) $display("FAIL rand_dat[%0d]: got %h expected %h", i, rdat, m_dat); else n_pass++;
      n_checks++; if (irq !== m_irq) $display("FAIL rand_irq[%0d]: got %b expected %b", i, irq, m_irq); else n_pass++;
    end
    clear_inputs();
    cycle();
  endtask

  task automatic test_reset_mid();
    logic a; logic [31:0] d, e;
    for (int i = 0; i < 30; i++) begin
      randomize_inputs();
      cycle();
    end
    stb = 1; we = 0; adr = {BASE, 24'h0, 2'd1, 2'b00};
    #2 rst = 0;
    #1;
    n_checks++; if (ack !== 1'b0) $display("FAIL midrst_ack: got %b expected 0", ack); else n_pass++;
    n_checks++; if (rdat !== 32'h0) $display("FAIL midrst_dat: got %h expected 0", rdat); else n_pass++;
    n_checks++; if (irq !== 1'b0) $display("FAIL midrst_irq: got %b expected 0", irq); else n_pass++;
    clear_inputs();
    @(posedge clk);
    #1;
    rst = 1;
    m_reset();
    wb_access(0, 2'd1, '0, a, d, e);
    n_checks++; if (a !== 1'b1) $display("FAIL midrst_next_ack: got %b expected 1", a); else n_pass++;
    n_checks++; if (d !== 32'h0000_0001) $display("FAIL midrst_status: got %h expected 00000001", d); else n_pass++;
    wb_access(0, 2'd2, '0, a, d, e);
    n_checks++; if (d !== 32'h0) $display("FAIL midrst_drops: got %h expected 0", d); else n_pass++;
  endtask

  initial begin
    n_pass = 0;
    n_checks = 0;
    rst = 0;
    m_reset();
    clear_inputs();
    test_reset();
    test_single_hit();
    test_wrong_dest();
    test_all_ports();
    test_overflow();
    test_empty_read();
    test_random();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
